r2sdf_twiddle_gen: RTL and testbench

//  Self-sequencing twiddle source for one R2SDF stage; successor of the per-stage cos/sin ROM.

---
 rtl/r2sdf_pkg.sv | 32 +++
 rtl/r2sdf_qrom.sv | 30 +++
 rtl/r2sdf_twiddle_gen.sv | 232 +++++++++++++++++++++++
 tb/tb_r2sdf_twiddle_gen.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/r2sdf_pkg.sv
// rtl/r2sdf_pkg.sv - shared constants, types and quarter-cosine table builder for the R2SDF twiddle source
package r2sdf_pkg;

  localparam int DW_DEF        = 16;
  localparam int LOG2N_MAX_DEF = 10;

  // Full-scale magnitude of a Q1.(DW-1) component, and table geometry for the default build
  localparam int FS   = (1 << (DW_DEF - 1)) - 1;
  localparam int NMAX = 1 << LOG2N_MAX_DEF;
  localparam int Q    = NMAX / 4;

  typedef struct packed {
    logic signed [31:0] re;
    logic signed [31:0] im;
  } cplx_t;

  function automatic int fs_of(input int dw);
    return (1 << (dw - 1)) - 1;
  endfunction

  // Entry idx of the quarter-wave table: round-nearest(cos(2*pi*idx/NMAX) * FS)
  function automatic int qcos_init(input int dw, input int log2n_max, input int idx);
    real pi_r;
    real ang;
    real v;
    pi_r = 3.14159265358979323846;
    ang  = 2.0 * pi_r * real'(idx) / real'(1 << log2n_max);
    v    = $cos(ang) * real'(fs_of(dw));
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

endpackage

// File: rtl/r2sdf_qrom.sv
// rtl/r2sdf_qrom.sv - quarter-wave cosine table with two registered read ports
module r2sdf_qrom
  import r2sdf_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int LOG2N_MAX = LOG2N_MAX_DEF
) (
  input  logic                    clk,
  input  logic [LOG2N_MAX-3:0]    re_addr,
  input  logic [LOG2N_MAX-3:0]    sn_addr,
  output logic signed [DW-1:0]    re_data,
  output logic signed [DW-1:0]    sn_data
);

  localparam int QDEPTH = 1 << (LOG2N_MAX - 2);

  logic signed [DW-1:0] tbl [QDEPTH];

  // Constant table contents; cos(0) entry is exactly full scale
  for (genvar i = 0; i < QDEPTH; i++) begin : g_tbl
    assign tbl[i] = DW'(qcos_init(DW, LOG2N_MAX, i));
  end

  // Both ports read the same table; the sine port reuses it through the Q-e mirror
  always_ff @(posedge clk) begin
    re_data <= tbl[re_addr];
    sn_data <= tbl[sn_addr];
  end

endmodule

// File: rtl/r2sdf_twiddle_gen.sv
// rtl/r2sdf_twiddle_gen.sv - self-sequencing R2SDF stage twiddle source; inverse support under `R2SDF_TW_INV_EN
module r2sdf_twiddle_gen
  import r2sdf_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int LOG2N_MAX = LOG2N_MAX_DEF
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               cfg_load,
  input  logic [$clog2(LOG2N_MAX+1)-1:0]     cfg_log2n,
  input  logic [$clog2(LOG2N_MAX)-1:0]       cfg_stage,
  input  logic                               cfg_inv,
  input  logic                               in_vld,
  output logic                               tw_vld,
  output logic signed [DW-1:0]               tw_re,
  output logic signed [DW-1:0]               tw_im,
  output logic                               tw_trivial,
  output logic                               blk_last
);

  localparam int LW = $clog2(LOG2N_MAX + 1);
  localparam int SW = $clog2(LOG2N_MAX);
  localparam int CW = LOG2N_MAX;
  localparam int AW = LOG2N_MAX - 2;

  // Latched configuration and sample counter
  logic [LW-1:0] log2n_q;
  logic [SW-1:0] stage_q;
  logic [CW-1:0] cnt;

  // Clamped incoming configuration and the configuration effective this cycle
  logic [LW-1:0] log2n_c, log2n_e, sh;
  logic [SW-1:0] stage_c, stage_e, stage_max;
  logic [CW-1:0] cnt_e, full_mask, blk_mask, half_mask, k;
  logic [CW-2:0] e;
  logic [AW-1:0] elo;
  logic          upper, quad, is_last;

  // S1 next-state values
  logic [AW-1:0] n_re_idx, n_sn_idx;
  logic          n_re_zero, n_sn_zero, n_re_neg, n_trivial;

  // S1 registers
  logic          s1_vld, s1_re_zero, s1_sn_zero, s1_re_neg, s1_trivial, s1_last;
  logic [AW-1:0] s1_re_idx, s1_sn_idx;

  // S2 registers (table data lives in the ROM's own output registers)
  logic          s2_vld, s2_re_zero, s2_sn_zero, s2_re_neg, s2_trivial, s2_last;
  logic signed [DW-1:0] rom_re, rom_sn, re_mag, sn_val;

`ifdef R2SDF_TW_INV_EN
  logic inv_q, inv_e, s1_inv, s2_inv;
`else
  logic unused_cfg_inv;
  assign unused_cfg_inv = cfg_inv;
`endif

  // Clamp the requested length and stage so the block size is always at least 2
  always_comb begin
    log2n_c = cfg_log2n;
    if (cfg_log2n < LW'(2)) begin
      log2n_c = LW'(2);
    end else if (cfg_log2n > LW'(LOG2N_MAX)) begin
      log2n_c = LW'(LOG2N_MAX);
    end
    stage_max = SW'(log2n_c - LW'(1));
    stage_c   = (cfg_stage > stage_max) ? stage_max : cfg_stage;
  end

  // A load takes effect on the sample of the same cycle, which becomes count 0
  always_comb begin
    log2n_e = cfg_load ? log2n_c : log2n_q;
    stage_e = cfg_load ? stage_c : stage_q;
    cnt_e   = cfg_load ? '0 : cnt;
`ifdef R2SDF_TW_INV_EN
    inv_e   = cfg_load ? cfg_inv : inv_q;
`endif
  end

  // Position within the block, phase and table exponent for the current sample
  always_comb begin
    sh        = log2n_e - LW'(stage_e);
    full_mask = {CW{1'b1}} >> (LW'(LOG2N_MAX) - log2n_e);
    blk_mask  = {CW{1'b1}} >> (LW'(LOG2N_MAX) - sh);
    half_mask = blk_mask >> 1;
    upper     = |(cnt_e & blk_mask & ~half_mask);
    k         = cnt_e & half_mask;
    e         = (CW-1)'((k << stage_e) << (LW'(LOG2N_MAX) - log2n_e));
    quad      = e[CW-2];
    elo       = e[AW-1:0];
    is_last   = (cnt_e == full_mask);
  end

  // Quadrant folding onto the quarter table; trivial samples read C[0] with sine forced to zero
  always_comb begin
    n_trivial = 1'b0;
    n_re_idx  = '0;
    n_sn_idx  = '0;
    n_re_zero = 1'b0;
    n_sn_zero = 1'b0;
    n_re_neg  = 1'b0;
    if (!upper) begin
      n_trivial = 1'b1;
      n_sn_zero = 1'b1;
    end else if (!quad) begin
      n_re_idx  = elo;
      n_sn_idx  = AW'(0) - elo;
      n_sn_zero = (elo == '0);
    end else begin
      n_re_idx  = AW'(0) - elo;
      n_re_zero = (elo == '0);
      n_re_neg  = 1'b1;
      n_sn_idx  = elo;
    end
  end

  // Configuration registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      log2n_q <= LW'(LOG2N_MAX);
      stage_q <= '0;
`ifdef R2SDF_TW_INV_EN
      inv_q   <= 1'b0;
`endif
    end else if (cfg_load) begin
      log2n_q <= log2n_c;
      stage_q <= stage_c;
`ifdef R2SDF_TW_INV_EN
      inv_q   <= cfg_inv;
`endif
    end
  end

  // Sample counter: one step per accepted sample, wrapping at the frame end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (in_vld) begin
      cnt <= is_last ? '0 : cnt_e + CW'(1);
    end else if (cfg_load) begin
      cnt <= '0;
    end
  end

  // S1: table indices, quadrant and flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld     <= 1'b0;
      s1_re_idx  <= '0;
      s1_sn_idx  <= '0;
      s1_re_zero <= 1'b0;
      s1_sn_zero <= 1'b0;
      s1_re_neg  <= 1'b0;
      s1_trivial <= 1'b0;
      s1_last    <= 1'b0;
`ifdef R2SDF_TW_INV_EN
      s1_inv     <= 1'b0;
`endif
    end else begin
      s1_vld     <= in_vld;
      s1_re_idx  <= n_re_idx;
      s1_sn_idx  <= n_sn_idx;
      s1_re_zero <= n_re_zero;
      s1_sn_zero <= n_sn_zero;
      s1_re_neg  <= n_re_neg;
      s1_trivial <= n_trivial;
      s1_last    <= is_last;
`ifdef R2SDF_TW_INV_EN
      s1_inv     <= inv_e;
`endif
    end
  end

  r2sdf_qrom #(
    .DW        (DW),
    .LOG2N_MAX (LOG2N_MAX)
  ) u_qrom (
    .clk     (clk),
    .re_addr (s1_re_idx),
    .sn_addr (s1_sn_idx),
    .re_data (rom_re),
    .sn_data (rom_sn)
  );

  // S2: sign-select flags aligned with the registered table data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_vld     <= 1'b0;
      s2_re_zero <= 1'b0;
      s2_sn_zero <= 1'b0;
      s2_re_neg  <= 1'b0;
      s2_trivial <= 1'b0;
      s2_last    <= 1'b0;
`ifdef R2SDF_TW_INV_EN
      s2_inv     <= 1'b0;
`endif
    end else begin
      s2_vld     <= s1_vld;
      s2_re_zero <= s1_re_zero;
      s2_sn_zero <= s1_sn_zero;
      s2_re_neg  <= s1_re_neg;
      s2_trivial <= s1_trivial;
      s2_last    <= s1_last;
`ifdef R2SDF_TW_INV_EN
      s2_inv     <= s1_inv;
`endif
    end
  end

  // Output muxing; outputs are held at zero whenever no twiddle is valid
  always_comb begin
    re_mag     = s2_re_zero ? '0 : rom_re;
    sn_val     = s2_sn_zero ? '0 : rom_sn;
    tw_vld     = s2_vld;
    tw_re      = '0;
    tw_im      = '0;
    tw_trivial = 1'b0;
    blk_last   = 1'b0;
    if (s2_vld) begin
      tw_re      = s2_re_neg ? -re_mag : re_mag;
`ifdef R2SDF_TW_INV_EN
      tw_im      = s2_inv ? sn_val : -sn_val;
`else
      tw_im      = -sn_val;
`endif
      tw_trivial = s2_trivial;
      blk_last   = s2_last;
    end
  end

endmodule

// File: tb/tb_r2sdf_twiddle_gen.sv
// tb/tb_r2sdf_twiddle_gen.sv - randomized self-checking bench for r2sdf_twiddle_gen against a trigonometric model
module tb_r2sdf_twiddle_gen;

  localparam int  DW  = 16;
  localparam int  L2M = 4;
  localparam int  LW  = $clog2(L2M + 1);
  localparam int  SW  = $clog2(L2M);
  localparam int  TFS = 32767;
  localparam real PI  = 3.14159265358979323846;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 cfg_load = 1'b0;
  logic [LW-1:0]        cfg_log2n = '0;
  logic [SW-1:0]        cfg_stage = '0;
  logic                 cfg_inv = 1'b0;
  logic                 in_vld = 1'b0;
  logic                 tw_vld, tw_trivial, blk_last;
  logic signed [DW-1:0] tw_re, tw_im;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int re;
    int im;
    bit triv;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  exp_t mx;

  int m_l2  = L2M;
  int m_s   = 0;
  int m_cnt = 0;
  bit m_inv = 1'b0;

  bit [1:0] vh     = 2'b00;
  bit       mon_en = 1'b0;

  r2sdf_twiddle_gen #(
    .DW        (DW),
    .LOG2N_MAX (L2M)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_load   (cfg_load),
    .cfg_log2n  (cfg_log2n),
    .cfg_stage  (cfg_stage),
    .cfg_inv    (cfg_inv),
    .in_vld     (in_vld),
    .tw_vld     (tw_vld),
    .tw_re      (tw_re),
    .tw_im      (tw_im),
    .tw_trivial (tw_trivial),
    .blk_last   (blk_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  function automatic int rnd(input real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

  // Drive one cycle of stimulus and, for accepted samples, queue the mathematically expected twiddle
  task automatic step(input bit vld, input bit load = 1'b0, input int l2 = 0, input int st = 0, input bit inv = 1'b0);
    exp_t x;
    int   n, mm, p;
    real  ang;
    in_vld    = vld;
    cfg_load  = load;
    cfg_log2n = LW'(l2);
    cfg_stage = SW'(st);
    cfg_inv   = inv;
    if (load) begin
      m_l2 = (l2 < 2) ? 2 : ((l2 > L2M) ? L2M : l2);
      m_s  = (st > m_l2 - 1) ? m_l2 - 1 : st;
`ifdef R2SDF_TW_INV_EN
      m_inv = inv;
`endif
      m_cnt = 0;
    end
    if (vld) begin
      n  = 1 << m_l2;
      mm = n >> m_s;
      p  = m_cnt % mm;
      x.last = (m_cnt == n - 1);
      if (p < mm / 2) begin
        x.re   = TFS;
        x.im   = 0;
        x.triv = 1'b1;
      end else begin
        ang    = 2.0 * PI * real'((p - mm / 2) * (1 << m_s)) / real'(n);
        x.re   = rnd($cos(ang) * real'(TFS));
        x.im   = -rnd($sin(ang) * real'(TFS));
        if (m_inv) x.im = -x.im;
        x.triv = 1'b0;
      end
      exp_q.push_back(x);
      m_cnt = (m_cnt + 1) % n;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_vld"},  tw_vld, 0);
    check({tag, "_re"},   tw_re, 0);
    check({tag, "_im"},   tw_im, 0);
    check({tag, "_triv"}, tw_trivial, 0);
    check({tag, "_last"}, blk_last, 0);
  endtask

  task automatic do_reset(input int cyc);
    rst_n    = 1'b0;
    in_vld   = 1'b0;
    cfg_load = 1'b0;
    repeat (cyc) @(posedge clk);
    #1;
    mon_en = 1'b1;
    check_idle_outputs("rst");
    exp_q.delete();
    m_l2  = L2M;
    m_s   = 0;
    m_inv = 1'b0;
    m_cnt = 0;
    rst_n = 1'b1;
  endtask

  // Expected tw_vld: accepted samples emerge two clocks later; reset drops everything in flight
  always @(posedge clk) begin
    if (!rst_n) vh <= 2'b00;
    else        vh <= {vh[0], in_vld};
  end

  // Scoreboard: compare each valid output against the next queued expectation
  always @(negedge clk) begin
    if (mon_en) begin
      check("tw_vld", tw_vld, vh[1]);
      if (tw_vld === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          mx = exp_q.pop_front();
          check("tw_re", tw_re, mx.re);
          check("tw_im", tw_im, mx.im);
          check("tw_trivial", tw_trivial, mx.triv);
          check("blk_last", blk_last, mx.last);
        end
      end
    end
  end

  initial begin
    do_reset(3);
    repeat (3) step(1'b0);
    check_idle_outputs("idle");

    // N=8, stage 0, forward: one full frame back to back
    step(1'b1, 1'b1, 3, 0, 1'b0);
    repeat (7) step(1'b1);
    // Stage 1 and an over-range stage that clamps to the last stage
    step(1'b1, 1'b1, 3, 1, 1'b0);
    repeat (7) step(1'b1);
    step(1'b1, 1'b1, 3, 3, 1'b0);
    repeat (7) step(1'b1);
    // Inverse request (conjugated only in builds with inverse support)
    step(1'b1, 1'b1, 3, 0, 1'b1);
    repeat (7) step(1'b1);
    // Gappy input: pattern 1,0,0,1
    step(1'b1, 1'b1, 3, 0, 1'b0);
    for (int i = 0; i < 15; i++) step((i % 4) == 2);
    // Reload in the middle of a frame at count 5
    step(1'b1, 1'b1, 3, 0, 1'b0);
    repeat (4) step(1'b1);
    step(1'b1, 1'b1, 2, 1, 1'b0);
    repeat (6) step(1'b1);
    // Reset at count 6, then a full frame in the reset configuration
    step(1'b1, 1'b1, 3, 0, 1'b0);
    repeat (5) step(1'b1);
    in_vld = 1'b1;
    do_reset(1);
    repeat (16) step(1'b1);
    // Randomized traffic with occasional reloads, including out-of-range lengths
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
           int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
    end
    repeat (4) step(1'b0);
    check("drain_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
